// File: rtl/time_set_ctrl_if.sv
// Key/tick inputs and display-facing outputs of time_set_ctrl.
// master drives the pulses and alarm_en; slave owns the registered digits.
interface time_set_ctrl_if;
    logic       tick_1hz;
    logic       key_mode;
    logic       key_shift;
    logic       key_inc;
    logic       alarm_en;
    logic [1:0] mode;
    logic [2:0] pos;
    logic [1:0] hour_tens;
    logic [3:0] hour_ones;
    logic [2:0] min_tens;
    logic [3:0] min_ones;
    logic [2:0] sec_tens;
    logic [3:0] sec_ones;
    logic [1:0] alarm_hour_tens;
    logic [3:0] alarm_hour_ones;
    logic [2:0] alarm_minute_tens;
    logic [3:0] alarm_minute_ones;
    logic       alarm_ring;
    logic       chime;

    modport master (
        output tick_1hz, key_mode, key_shift, key_inc, alarm_en,
        input  mode, pos,
        input  hour_tens, hour_ones, min_tens, min_ones,
        input  sec_tens, sec_ones,
        input  alarm_hour_tens, alarm_hour_ones,
        input  alarm_minute_tens, alarm_minute_ones,
        input  alarm_ring, chime
    );

    modport slave (
        input  tick_1hz, key_mode, key_shift, key_inc, alarm_en,
        output mode, pos,
        output hour_tens, hour_ones, min_tens, min_ones,
        output sec_tens, sec_ones,
        output alarm_hour_tens, alarm_hour_ones,
        output alarm_minute_tens, alarm_minute_ones,
        output alarm_ring, chime
    );
endinterface

// File: rtl/time_set_ctrl.sv
// Time-of-day BCD counters, alarm registers and mode/pos FSM.
// Define CHIME_EN to generate the hourly chime pulse; otherwise chime is 0.
module time_set_ctrl #(
    parameter int TIMEOUT_TICKS = 30,
    parameter int RING_TICKS    = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    time_set_ctrl_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    localparam int RW = $clog2(RING_TICKS + 1);

    typedef enum logic [1:0] {
        NORMAL    = 2'b00,
        CLOCK_SET = 2'b01,
        ALARM_SET = 2'b10
    } mode_e;

    mode_e         state_q, state_d;
    logic [2:0]    pos_q, pos_d;
    logic [1:0]    ht_q, ht_d;
    logic [3:0]    ho_q, ho_d;
    logic [2:0]    mt_q, mt_d;
    logic [3:0]    mo_q, mo_d;
    logic [2:0]    st_q, st_d;
    logic [3:0]    so_q, so_d;
    logic [1:0]    aht_q, aht_d;
    logic [3:0]    aho_q, aho_d;
    logic [2:0]    amt_q, amt_d;
    logic [3:0]    amo_q, amo_d;
    logic [TW-1:0] to_q, to_d;
    logic          ring_q, ring_d;
    logic [RW-1:0] rcnt_q, rcnt_d;

    logic       any_key, timeout, consume, accept;
    logic       do_mode, do_shift, do_inc, run, fire;
    logic       sec_wrap, min_wrap, hr_c, day_end;
    logic [1:0] nht;
    logic [3:0] nho;
    logic [2:0] nmt;
    logic [3:0] nmo;
    logic [2:0] nst;
    logic [3:0] nso;

    // Timeout beats every key; a ringing alarm swallows the key that silences it.
    always_comb begin
        any_key  = bus.key_mode | bus.key_shift | bus.key_inc;
        timeout  = (state_q != NORMAL) && bus.tick_1hz &&
                   (to_q == TW'(TIMEOUT_TICKS - 1));
        consume  = ring_q && any_key;
        accept   = !timeout && !consume;
        do_mode  = accept && bus.key_mode;
        do_shift = accept && !bus.key_mode && bus.key_shift;
        do_inc   = accept && !bus.key_mode && !bus.key_shift &&
                   bus.key_inc;
        run      = bus.tick_1hz && (state_q != CLOCK_SET);
    end

    always_comb begin
        sec_wrap = (so_q == 4'd9) && (st_q == 3'd5);
        min_wrap = (mo_q == 4'd9) && (mt_q == 3'd5);
        hr_c     = sec_wrap && min_wrap;
        day_end  = (ht_q == 2'd2) && (ho_q == 4'd3);
        nso = (so_q == 4'd9) ? 4'd0 : so_q + 4'd1;
        nst = st_q;
        if (so_q == 4'd9) begin
            nst = (st_q == 3'd5) ? 3'd0 : st_q + 3'd1;
        end
        nmo = mo_q;
        if (sec_wrap) begin
            nmo = (mo_q == 4'd9) ? 4'd0 : mo_q + 4'd1;
        end
        nmt = mt_q;
        if (sec_wrap && (mo_q == 4'd9)) begin
            nmt = (mt_q == 3'd5) ? 3'd0 : mt_q + 3'd1;
        end
        nho = ho_q;
        nht = ht_q;
        if (hr_c) begin
            if (day_end) begin
                nho = 4'd0;
                nht = 2'd0;
            end else if (ho_q == 4'd9) begin
                nho = 4'd0;
                nht = ht_q + 2'd1;
            end else begin
                nho = ho_q + 4'd1;
            end
        end
    end

    always_comb begin
        fire = run && (state_q == NORMAL) && bus.alarm_en &&
               (nht == aht_q) && (nho == aho_q) &&
               (nmt == amt_q) && (nmo == amo_q) &&
               (nst == 3'd0) && (nso == 4'd0);
    end

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        if (timeout) begin
            state_d = NORMAL;
            pos_d   = 3'd0;
        end else if (do_mode) begin
            unique case (state_q)
                NORMAL: begin
                    state_d = CLOCK_SET;
                    pos_d   = 3'd1;
                end
                CLOCK_SET: begin
                    state_d = ALARM_SET;
                    pos_d   = 3'd1;
                end
                default: begin
                    state_d = NORMAL;
                    pos_d   = 3'd0;
                end
            endcase
        end else if (do_shift) begin
            if (state_q == CLOCK_SET) begin
                pos_d = (pos_q == 3'd6) ? 3'd1 : pos_q + 3'd1;
            end else if (state_q == ALARM_SET) begin
                pos_d = (pos_q == 3'd4) ? 3'd1 : pos_q + 3'd1;
            end
        end
    end

    // Digit edits wrap inside the digit; no carry into neighbours.
    always_comb begin
        ht_d = ht_q;
        ho_d = ho_q;
        mt_d = mt_q;
        mo_d = mo_q;
        st_d = st_q;
        so_d = so_q;
        if (run) begin
            ht_d = nht;
            ho_d = nho;
            mt_d = nmt;
            mo_d = nmo;
            st_d = nst;
            so_d = nso;
        end else if (do_inc && (state_q == CLOCK_SET)) begin
            unique case (1'b1)
                pos_q == 3'd1: begin
                    ht_d = (ht_q == 2'd2) ? 2'd0 : ht_q + 2'd1;
                    if ((ht_q == 2'd1) && (ho_q > 4'd3)) ho_d = 4'd3;
                end
                pos_q == 3'd2: begin
                    if (ht_q == 2'd2) begin
                        ho_d = (ho_q == 4'd3) ? 4'd0 : ho_q + 4'd1;
                    end else begin
                        ho_d = (ho_q == 4'd9) ? 4'd0 : ho_q + 4'd1;
                    end
                end
                pos_q == 3'd3: mt_d = (mt_q == 3'd5) ? 3'd0 : mt_q + 3'd1;
                pos_q == 3'd4: mo_d = (mo_q == 4'd9) ? 4'd0 : mo_q + 4'd1;
                pos_q == 3'd5: st_d = (st_q == 3'd5) ? 3'd0 : st_q + 3'd1;
                pos_q == 3'd6: so_d = (so_q == 4'd9) ? 4'd0 : so_q + 4'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        aht_d = aht_q;
        aho_d = aho_q;
        amt_d = amt_q;
        amo_d = amo_q;
        if (do_inc && (state_q == ALARM_SET)) begin
            unique case (1'b1)
                pos_q == 3'd1: begin
                    aht_d = (aht_q == 2'd2) ? 2'd0 : aht_q + 2'd1;
                    if ((aht_q == 2'd1) && (aho_q > 4'd3)) aho_d = 4'd3;
                end
                pos_q == 3'd2: begin
                    if (aht_q == 2'd2) begin
                        aho_d = (aho_q == 4'd3) ? 4'd0 : aho_q + 4'd1;
                    end else begin
                        aho_d = (aho_q == 4'd9) ? 4'd0 : aho_q + 4'd1;
                    end
                end
                pos_q == 3'd3: amt_d = (amt_q == 3'd5) ? 3'd0 : amt_q + 3'd1;
                pos_q == 3'd4: amo_d = (amo_q == 4'd9) ? 4'd0 : amo_q + 4'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        to_d = to_q;
        if ((state_q == NORMAL) || (state_d != state_q) || any_key) begin
            to_d = '0;
        end else if (bus.tick_1hz) begin
            to_d = to_q + TW'(1);
        end
    end

    always_comb begin
        ring_d = ring_q;
        rcnt_d = rcnt_q;
        if (!bus.alarm_en) begin
            ring_d = 1'b0;
            rcnt_d = '0;
        end else if (fire) begin
            ring_d = 1'b1;
            rcnt_d = RW'(RING_TICKS);
        end else if (consume) begin
            ring_d = 1'b0;
            rcnt_d = '0;
        end else if (ring_q && bus.tick_1hz) begin
            rcnt_d = rcnt_q - RW'(1);
            if (rcnt_q == RW'(1)) ring_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= NORMAL;
            pos_q   <= 3'd0;
            ht_q    <= 2'd0;
            ho_q    <= 4'd0;
            mt_q    <= 3'd0;
            mo_q    <= 4'd0;
            st_q    <= 3'd0;
            so_q    <= 4'd0;
            aht_q   <= 2'd0;
            aho_q   <= 4'd7;
            amt_q   <= 3'd0;
            amo_q   <= 4'd0;
            to_q    <= '0;
            ring_q  <= 1'b0;
            rcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            ht_q    <= ht_d;
            ho_q    <= ho_d;
            mt_q    <= mt_d;
            mo_q    <= mo_d;
            st_q    <= st_d;
            so_q    <= so_d;
            aht_q   <= aht_d;
            aho_q   <= aho_d;
            amt_q   <= amt_d;
            amo_q   <= amo_d;
            to_q    <= to_d;
            ring_q  <= ring_d;
            rcnt_q  <= rcnt_d;
        end
    end

`ifdef CHIME_EN
    logic chime_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chime_q <= 1'b0;
        end else begin
            chime_q <= run && hr_c;
        end
    end

    assign bus.chime = chime_q;
`else
    assign bus.chime = 1'b0;
`endif

    assign bus.mode              = state_q;
    assign bus.pos               = pos_q;
    assign bus.hour_tens         = ht_q;
    assign bus.hour_ones         = ho_q;
    assign bus.min_tens          = mt_q;
    assign bus.min_ones          = mo_q;
    assign bus.sec_tens          = st_q;
    assign bus.sec_ones          = so_q;
    assign bus.alarm_hour_tens   = aht_q;
    assign bus.alarm_hour_ones   = aho_q;
    assign bus.alarm_minute_tens = amt_q;
    assign bus.alarm_minute_ones = amo_q;
    assign bus.alarm_ring        = ring_q;
endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed + random bench for time_set_ctrl against a seconds-of-day model.
// Build with CHIME_EN defined to expect hourly chime pulses.
module tb_time_set_ctrl;
    localparam int TIMEOUT_TICKS = 30;
    localparam int RING_TICKS    = 10;
`ifdef CHIME_EN
    localparam bit CHIME = 1'b1;
`else
    localparam bit CHIME = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    time_set_ctrl_if bus ();

    time_set_ctrl #(
        .TIMEOUT_TICKS(TIMEOUT_TICKS),
        .RING_TICKS   (RING_TICKS)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int    checks   = 0;
    int    failures = 0;
    string phase    = "reset";

    // Model: time as seconds of day, alarm as minutes of day.
    int m_mode, m_pos, m_secs, m_alarm, m_to, m_rcnt;
    bit m_ring, m_chime;
    bit ae;

    function automatic logic [19:0] exp_time(int t);
        int h, m, s;
        h = t / 3600;
        m = (t / 60) % 60;
        s = t % 60;
        return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10),
                3'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [12:0] exp_alarm(int a);
        int h, m;
        h = a / 60;
        m = a % 60;
        return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10)};
    endfunction

    function automatic logic [19:0] obs_time();
        return {bus.hour_tens, bus.hour_ones, bus.min_tens,
                bus.min_ones, bus.sec_tens, bus.sec_ones};
    endfunction

    function automatic logic [12:0] obs_alarm();
        return {bus.alarm_hour_tens, bus.alarm_hour_ones,
                bus.alarm_minute_tens, bus.alarm_minute_ones};
    endfunction

    function automatic int edit(int t, int p);
        int d[6];
        int h, m, s;
        h = t / 3600;
        m = (t / 60) % 60;
        s = t % 60;
        d = '{h / 10, h % 10, m / 10, m % 10, s / 10, s % 10};
        case (p)
            1: begin
                d[0] = (d[0] + 1) % 3;
                if (d[0] == 2 && d[1] > 3) d[1] = 3;
            end
            2: d[1] = (d[1] + 1) % ((d[0] == 2) ? 4 : 10);
            3: d[2] = (d[2] + 1) % 6;
            4: d[3] = (d[3] + 1) % 10;
            5: d[4] = (d[4] + 1) % 6;
            default: d[5] = (d[5] + 1) % 10;
        endcase
        return (d[0] * 10 + d[1]) * 3600 + (d[2] * 10 + d[3]) * 60 +
               d[4] * 10 + d[5];
    endfunction

    function automatic int cur_digit(int p);
        int t, h, m, s;
        t = (m_mode == 2) ? m_alarm * 60 : m_secs;
        h = t / 3600;
        m = (t / 60) % 60;
        s = t % 60;
        case (p)
            1: return h / 10;
            2: return h % 10;
            3: return m / 10;
            4: return m % 10;
            5: return s / 10;
            default: return s % 10;
        endcase
    endfunction

    task automatic model_reset();
        m_mode  = 0;
        m_pos   = 0;
        m_secs  = 0;
        m_alarm = 7 * 60;
        m_to    = 0;
        m_rcnt  = 0;
        m_ring  = 1'b0;
        m_chime = 1'b0;
    endtask

    task automatic model_step(input bit km, ks, ki, tk);
        bit anyk, tmo, cons, dm, ds, di, run, fire;
        int nmode, npos, nsecs, nal;
        anyk = km | ks | ki;
        tmo  = (m_mode != 0) && tk && (m_to == TIMEOUT_TICKS - 1);
        cons = m_ring && anyk;
        dm   = !tmo && !cons && km;
        ds   = !tmo && !cons && !km && ks;
        di   = !tmo && !cons && !km && !ks && ki;
        nmode = m_mode;
        npos  = m_pos;
        if (tmo) begin
            nmode = 0;
            npos  = 0;
        end else if (dm) begin
            nmode = (m_mode + 1) % 3;
            npos  = (nmode == 0) ? 0 : 1;
        end else if (ds && m_mode == 1) begin
            npos = m_pos % 6 + 1;
        end else if (ds && m_mode == 2) begin
            npos = m_pos % 4 + 1;
        end
        run   = tk && (m_mode != 1);
        nsecs = run ? (m_secs + 1) % 86400 : m_secs;
        nal   = m_alarm;
        if (di && m_mode == 1) nsecs = edit(m_secs, m_pos);
        if (di && m_mode == 2) nal = edit(m_alarm * 60, m_pos) / 60;
        fire = run && (m_mode == 0) && ae && (nsecs == m_alarm * 60);
        if (!ae) begin
            m_ring = 1'b0;
            m_rcnt = 0;
        end else if (fire) begin
            m_ring = 1'b1;
            m_rcnt = RING_TICKS;
        end else if (cons) begin
            m_ring = 1'b0;
            m_rcnt = 0;
        end else if (m_ring && tk) begin
            m_rcnt--;
            if (m_rcnt == 0) m_ring = 1'b0;
        end
        m_chime = CHIME && run && (nsecs % 3600 == 0);
        if (m_mode == 0 || nmode != m_mode || anyk) m_to = 0;
        else if (tk) m_to++;
        m_mode  = nmode;
        m_pos   = npos;
        m_secs  = nsecs;
        m_alarm = nal;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s/%s observed=%0h expected=%0h",
                   phase, tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("mode",  32'(bus.mode),       32'(m_mode));
        chk("pos",   32'(bus.pos),        32'(m_pos));
        chk("time",  32'(obs_time()),     32'(exp_time(m_secs)));
        chk("alarm", 32'(obs_alarm()),    32'(exp_alarm(m_alarm)));
        chk("ring",  32'(bus.alarm_ring), 32'(m_ring));
        chk("chime", 32'(bus.chime),      32'(m_chime));
    endtask

    task automatic cyc(input bit km, ks, ki, tk);
        bus.key_mode  = km;
        bus.key_shift = ks;
        bus.key_inc   = ki;
        bus.tick_1hz  = tk;
        bus.alarm_en  = ae;
        @(posedge clk);
        model_step(km, ks, ki, tk);
        #1;
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 1);
    endtask

    task automatic goto_mode(input int md);
        for (int i = 0; i < 6; i++) begin
            if (m_mode == md) break;
            cyc(1, 0, 0, 0);
        end
    endtask

    task automatic goto_pos(input int p);
        for (int i = 0; i < 8; i++) begin
            if (m_pos == p) break;
            cyc(0, 1, 0, 0);
        end
    endtask

    task automatic set_digit(input int p, input int v);
        goto_pos(p);
        for (int i = 0; i < 12; i++) begin
            if (cur_digit(p) == v) break;
            cyc(0, 0, 1, 0);
        end
    endtask

    initial begin
        int tgt;
        bus.key_mode  = 1'b0;
        bus.key_shift = 1'b0;
        bus.key_inc   = 1'b0;
        bus.tick_1hz  = 1'b0;
        bus.alarm_en  = 1'b0;
        ae = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("rst_alarm", 32'(obs_alarm()), 32'(13'b00_0111_000_0000));
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, 0, 0, 0);

        phase = "shift";
        cyc(1, 0, 0, 0);
        repeat (5) cyc(0, 1, 0, 0);
        chk("pos6", 32'(bus.pos), 32'd6);
        cyc(0, 1, 0, 0);
        chk("pos_wrap", 32'(bus.pos), 32'd1);
        ticks(5);
        chk("frozen", 32'(obs_time()), 32'd0);

        phase = "clamp";
        set_digit(1, 1);
        set_digit(2, 9);
        chk("h19", 32'({bus.hour_tens, bus.hour_ones}), 32'h19);
        goto_pos(1);
        cyc(0, 0, 1, 0);
        chk("h23", 32'({bus.hour_tens, bus.hour_ones}), 32'h23);
        cyc(0, 0, 1, 0);
        chk("h03", 32'({bus.hour_tens, bus.hour_ones}), 32'h03);

        phase = "timeout";
        ticks(TIMEOUT_TICKS - 1);
        chk("to_hold", 32'(bus.mode), 32'd1);
        ticks(1);
        chk("to_mode", 32'(bus.mode), 32'd0);
        chk("to_pos", 32'(bus.pos), 32'd0);
        cyc(1, 0, 1, 0);
        chk("prio_mode", 32'(bus.mode), 32'd1);
        chk("prio_time", 32'(obs_time()), 32'(exp_time(3 * 3600)));
        goto_mode(0);

        phase = "alarm";
        goto_mode(2);
        set_digit(1, 0);
        set_digit(2, 3);
        set_digit(3, 0);
        set_digit(4, 1);
        goto_mode(0);
        ae = 1'b1;
        ticks(60);
        chk("ring_on", 32'(bus.alarm_ring), 32'd1);
        ticks(RING_TICKS - 1);
        chk("ring_hold", 32'(bus.alarm_ring), 32'd1);
        ticks(1);
        chk("ring_end", 32'(bus.alarm_ring), 32'd0);
        goto_mode(2);
        set_digit(4, 2);
        goto_mode(0);
        ticks(50);
        chk("ring2_on", 32'(bus.alarm_ring), 32'd1);
        ticks(3);
        cyc(0, 1, 0, 0);
        chk("key_clear", 32'(bus.alarm_ring), 32'd0);
        chk("key_eaten", 32'(bus.mode), 32'd0);
        goto_mode(2);
        set_digit(4, 3);
        goto_mode(0);
        ticks(57);
        chk("ring3_on", 32'(bus.alarm_ring), 32'd1);
        ae = 1'b0;
        cyc(0, 0, 0, 0);
        chk("en_clear", 32'(bus.alarm_ring), 32'd0);
        ae = 1'b1;

        phase = "rollover";
        goto_mode(1);
        set_digit(1, 2);
        set_digit(2, 3);
        set_digit(3, 5);
        set_digit(4, 9);
        set_digit(5, 5);
        set_digit(6, 0);
        goto_mode(0);
        ticks(9);
        chk("t235959", 32'(obs_time()), 32'(exp_time(86399)));
        ticks(1);
        chk("t000000", 32'(obs_time()), 32'd0);
        chk("chime_roll", 32'(bus.chime), 32'(CHIME));

        phase = "chime";
        goto_mode(1);
        set_digit(3, 5);
        set_digit(4, 9);
        set_digit(5, 5);
        set_digit(6, 0);
        goto_mode(0);
        ticks(10);
        chk("t010000", 32'(obs_time()), 32'(exp_time(3600)));
        chk("chime_hr", 32'(bus.chime), 32'(CHIME));
        cyc(0, 0, 0, 0);
        chk("chime_pulse", 32'(bus.chime), 32'd0);

        phase = "random";
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 96) == 0) ae = ~ae;
            cyc(bit'($urandom_range(0, 29) == 0),
                bit'($urandom_range(0, 9) == 0),
                bit'($urandom_range(0, 5) == 0),
                bit'($urandom_range(0, 1)));
        end

        phase = "reset_ring";
        ae = 1'b1;
        goto_mode(2);
        tgt = (m_secs / 60 + 1) % 1440;
        set_digit(1, tgt / 600);
        set_digit(2, (tgt / 60) % 10);
        set_digit(3, (tgt % 60) / 10);
        set_digit(4, tgt % 10);
        goto_mode(0);
        for (int i = 0; i < 70; i++) begin
            if (m_ring) break;
            cyc(0, 0, 0, 1);
        end
        chk("ring_pre", 32'(bus.alarm_ring), 32'd1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        ticks(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
